adc_spi_reader: RTL

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_spi_reader_if.sv | 51 +++++
 rtl/adc_phase_timer.sv | 37 +++
 rtl/adc_spi_reader.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state encoding and default sizing for the ADC SPI reader.
// The optional overrun flag is enabled with the ADC_OVERRUN_EN macro.
package adc_pkg;

  localparam int unsigned DefWidth = 12;
  localparam int unsigned DefDivW  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StShift = 2'd2,
    StHold  = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if: request/serial/result signals of the ADC SPI reader.
// Port names keep their direction suffix as seen from the reader (slave modport).
// The overrun_o member only exists when ADC_OVERRUN_EN is defined.
interface adc_spi_reader_if #(
  parameter int unsigned Width = 12,
  parameter int unsigned DivW  = 8
);

  logic             start_i;
  logic [DivW-1:0]  div_i;
  logic             miso_i;
  logic             cs_o;
  logic             sclk_o;
  logic [Width-1:0] data_o;
  logic             done_o;
  logic             busy_o;
`ifdef ADC_OVERRUN_EN
  logic             overrun_o;
`endif

  modport slave (
    input  start_i,
    input  div_i,
    input  miso_i,
    output cs_o,
    output sclk_o,
    output data_o,
    output done_o,
    output busy_o
`ifdef ADC_OVERRUN_EN
    ,
    output overrun_o
`endif
  );

  modport master (
    output start_i,
    output div_i,
    output miso_i,
    input  cs_o,
    input  sclk_o,
    input  data_o,
    input  done_o,
    input  busy_o
`ifdef ADC_OVERRUN_EN
    ,
    input  overrun_o
`endif
  );

endinterface

// File: rtl/adc_phase_timer.sv
// adc_phase_timer: reloadable down-counter; phase_end_o pulses for one cycle when the
// count sits at zero while enabled, so each phase lasts load value + 1 cycles.
module adc_phase_timer #(
  parameter int unsigned DivW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [DivW-1:0] load_val_i,
  output logic            phase_end_o
);

  logic [DivW-1:0] count_q, count_d;

  // Next count: reload has priority, otherwise count down to zero and stop.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - DivW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase_end_o = en_i && (count_q == '0);

endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI mode-0 reader for a serial ADC. A start tick runs
// SETUP -> Width SCLK pulses (MSB first) -> HOLD, then publishes the word with a done pulse.
// Define ADC_OVERRUN_EN to add a sticky overrun_o flag for starts arriving while busy.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned DivW  = DefDivW
) (
  input logic             clk_i,
  input logic             rst_i,
  adc_spi_reader_if.slave adc_if
);

  localparam int unsigned CntW = $clog2(Width + 1);

  adc_state_e       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [Width-1:0] shreg_q, shreg_d;
  logic [Width-1:0] data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;

  logic             busy;
  logic             start_acc;
  logic             phase_end;
  logic             tmr_load;
  logic [DivW-1:0]  tmr_val;

  assign busy = (state_q != StIdle);
  // A start landing on the done cycle is dropped, not queued.
  assign start_acc = (state_q == StIdle) && adc_if.start_i && !done_q;

  // First phase is timed from the live divisor; later phases from the latched copy.
  assign tmr_load = start_acc || phase_end;
  assign tmr_val  = start_acc ? adc_if.div_i : div_q;

  adc_phase_timer #(
    .DivW (DivW)
  ) u_phase_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (busy),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .phase_end_o (phase_end)
  );

  // Next-state logic: phase sequencing, SCLK generation, MISO sampling on rising SCLK.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d   = StSetup;
          div_d     = adc_if.div_i;
          bit_cnt_d = '0;
        end
      end
      StSetup: begin
        if (phase_end) begin
          state_d = StShift;
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[Width-2:0], adc_if.miso_i};
        end
      end
      StShift: begin
        if (phase_end) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end else if (bit_cnt_q == CntW'(Width)) begin
            // Low half after the last falling edge has elapsed.
            state_d = StHold;
          end else begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[Width-2:0], adc_if.miso_i};
          end
        end
      end
      StHold: begin
        if (phase_end) begin
          state_d = StIdle;
          data_d  = shreg_q;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

  assign adc_if.cs_o   = !busy;
  assign adc_if.sclk_o = sclk_q;
  assign adc_if.data_o = data_q;
  assign adc_if.done_o = done_q;
  assign adc_if.busy_o = busy;

`ifdef ADC_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: any start seen while a transfer is running; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
    end else if (adc_if.start_i && busy) begin
      overrun_q <= 1'b1;
    end
  end

  assign adc_if.overrun_o = overrun_q;
`endif

endmodule
